multi_servo_sequencer: RTL

MULTI_SERVO_SEQUENCER -- requirements
Module: multi_servo_sequencer

---
 rtl/servo_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/multi_servo_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the multi-servo sequencer.
//   seq_state_e : sequencer FSM states; the encoding doubles as the hex-display code
//   pulse_clks  : PWM high-time in clocks for a position code (T_MIN + pos*T_STEP)
package servo_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_APPLY  = 4'd2,
        ST_SETTLE = 4'd3,
        ST_DONE   = 4'd4
    } seq_state_e;

    // Evaluated at 32 bits so the product cannot wrap before the caller narrows
    // the result to the PWM counter width.
    function automatic logic [31:0] pulse_clks(input logic [31:0] t_min,
                                               input logic [31:0] t_step,
                                               input logic [31:0] pos);
        return t_min + pos * t_step;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO used as the servo command queue.
// Ports:
//   clock, reset     : system clock, asynchronous active-low reset
//   push_i / wdata_i : write request and data (ignored when full)
//   pop_i  / rdata_o : read request; rdata_o always shows the head entry
//   flush_i          : synchronous empty, wins over push and pop
//   count_o          : number of stored entries (0..DEPTH)
//   full_o / empty_o : status flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/multi_servo_sequencer.sv
// Queued position sequencer driving N_CH hobby servos with glitch-free PWM.
// Ports:
//   clock, reset          : system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_ch/cmd_pos carry channel and position
//   abort                 : synchronous flush of queue and FSM
//   pwm                   : registered PWM outputs, one per channel
//   busy, done, err       : status; done and err are one-cycle pulses
//   fifo_count, db_estado : queue occupancy and FSM state code
//
// state     | meaning
// IDLE   0  | waiting for a queued command
// LOAD   1  | pop queue head into the current-command register
// APPLY  2  | write the target pulse of the current channel
// SETTLE 3  | wait SETTLE_CYC cycles for the servo to move
// DONE   4  | report completion (done pulse)
module multi_servo_sequencer
    import servo_pkg::*;
#(
    parameter int N_CH       = 3,
    parameter int POS_W      = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int PERIOD     = 1_000_000,
    parameter int T_MIN      = 50_000,
    parameter int T_STEP     = 25_000,
    parameter int SETTLE_CYC = 25_000_000,
    parameter int HOME_POS   = 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   cmd_valid,
    output logic                                   cmd_ready,
    input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] cmd_ch,
    input  logic [POS_W-1:0]                       cmd_pos,
    input  logic                                   abort,
    output logic [N_CH-1:0]                        pwm,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   err,
    output logic [$clog2(FIFO_DEPTH):0]            fifo_count,
    output logic [3:0]                             db_estado
);
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int PW    = $clog2(PERIOD) + 1;
    localparam int SW    = $clog2(SETTLE_CYC) + 1;

    localparam logic [PW-1:0]   PERIOD_M1  = PW'(PERIOD - 1);
    localparam logic [PW-1:0]   PW_ONE     = PW'(1);
    localparam logic [PW-1:0]   HOME_PULSE = PW'(pulse_clks(32'(T_MIN), 32'(T_STEP), 32'(HOME_POS)));
    localparam logic [SW-1:0]   SETTLE_M1  = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0]   SW_ONE     = SW'(1);
    localparam logic [CH_W:0]   N_CH_C     = (CH_W + 1)'(N_CH);

    seq_state_e          state_q, state_d;
    logic [SW-1:0]       settle_q, settle_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [POS_W-1:0]    cur_pos_q, cur_pos_d;
    logic [PW-1:0]       target_q [N_CH];
    logic [PW-1:0]       target_d [N_CH];
    logic [PW-1:0]       active_q [N_CH];
    logic [PW-1:0]       period_cnt_q;
    logic                period_wrap;
    logic [N_CH-1:0]     pwm_q;
    logic                err_q;

    logic                hs, ch_ok, fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CH_W+POS_W-1:0] fifo_rdata;
    logic [CNT_W-1:0]    fifo_cnt;

    assign hs        = cmd_valid & cmd_ready;
    assign ch_ok     = ({1'b0, cmd_ch} < N_CH_C);
    // abort drops any handshake in the same cycle.
    assign fifo_push = hs & ch_ok & ~abort;

    sync_fifo #(
        .WIDTH (CH_W + POS_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (fifo_push),
        .wdata_i ({cmd_ch, cmd_pos}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .flush_i (abort),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cur_ch_d  = cur_ch_q;
        cur_pos_d = cur_pos_q;
        target_d  = target_q;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                fifo_pop               = 1'b1;
                {cur_ch_d, cur_pos_d}  = fifo_rdata;
                state_d                = ST_APPLY;
            end
            ST_APPLY: begin
                for (int i = 0; i < N_CH; i++) begin
                    if (cur_ch_q == CH_W'(i))
                        target_d[i] = PW'(pulse_clks(32'(T_MIN), 32'(T_STEP), 32'(cur_pos_q)));
                end
                settle_d = SETTLE_M1;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (settle_q == '0) state_d = ST_DONE;
                else                settle_d = settle_q - SW_ONE;
            end
            ST_DONE: begin
                // Queued work skips the IDLE cycle so back-to-back moves
                // complete every SETTLE_CYC+3 cycles.
                state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d  = ST_IDLE;
            fifo_pop = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            cur_ch_q  <= '0;
            cur_pos_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < N_CH; i++) target_q[i] <= HOME_PULSE;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            cur_ch_q  <= cur_ch_d;
            cur_pos_q <= cur_pos_d;
            err_q     <= hs & ~ch_ok & ~abort;
            for (int i = 0; i < N_CH; i++) target_q[i] <= target_d[i];
        end
    end

    // Active pulses only change at the period boundary, so every period is
    // generated entirely with one pulse width.
    assign period_wrap = (period_cnt_q == PERIOD_M1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            period_cnt_q <= '0;
            pwm_q        <= '0;
            for (int i = 0; i < N_CH; i++) active_q[i] <= HOME_PULSE;
        end else begin
            period_cnt_q <= period_wrap ? '0 : period_cnt_q + PW_ONE;
            for (int i = 0; i < N_CH; i++) begin
                if (period_wrap) active_q[i] <= target_q[i];
                pwm_q[i] <= (period_cnt_q < active_q[i]);
            end
        end
    end

    assign cmd_ready  = ~fifo_full;
    assign done       = (state_q == ST_DONE) & ~abort;
    assign err        = err_q;
    assign busy       = (state_q != ST_IDLE) | (fifo_cnt != '0);
    assign fifo_count = fifo_cnt;
    assign db_estado  = state_q;
    assign pwm        = pwm_q;

endmodule
